// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences each instruction through
// IDLE/FETCH/DECODE/EXE/MEM/WB, waits on mem_ready, with a bus-timeout watchdog.
module mc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [1:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXE  = 3'd3, S_MEM   = 3'd4, S_WB     = 3'd5;

  localparam logic [3:0] C_NONE = 4'd0,  C_ADD  = 4'd1,  C_SUB  = 4'd2,
                         C_AND  = 4'd3,  C_OR   = 4'd4,  C_SLT  = 4'd5,
                         C_SLTU = 4'd6,  C_SLL  = 4'd7,  C_SRL  = 4'd8,
                         C_SLLV = 4'd9,  C_SRLV = 4'd10, C_ADDI = 4'd11,
                         C_ORI  = 4'd12, C_LW   = 4'd13, C_SW   = 4'd14,
                         C_BEQ  = 4'd15;

  logic [2:0]        r_state, w_next;
  logic [3:0]        r_class, w_class;
  logic [WAIT_W-1:0] r_wait;
  logic              r_bus_err;
  logic              w_is_j, w_is_jal, w_wait, w_timeout;

  // Instruction decode; j/jal retire in DECODE so they need no class code
  always_comb begin
    w_class  = C_NONE;
    w_is_j   = 1'b0;
    w_is_jal = 1'b0;
    case (Op)
      6'b000000: begin
        case (Funct)
          6'b100000, 6'b100001: w_class = C_ADD;
          6'b100010, 6'b100011: w_class = C_SUB;
          6'b100100:            w_class = C_AND;
          6'b100101:            w_class = C_OR;
          6'b101010:            w_class = C_SLT;
          6'b101011:            w_class = C_SLTU;
          6'b000000:            w_class = C_SLL;
          6'b000010:            w_class = C_SRL;
          6'b000100:            w_class = C_SLLV;
          6'b000110:            w_class = C_SRLV;
          default:              w_class = C_NONE;
        endcase
      end
      6'b001000: w_class  = C_ADDI;
      6'b001101: w_class  = C_ORI;
      6'b100011: w_class  = C_LW;
      6'b101011: w_class  = C_SW;
      6'b000100: w_class  = C_BEQ;
      6'b000010: w_is_j   = 1'b1;
      6'b000011: w_is_jal = 1'b1;
      default:   w_class  = C_NONE;
    endcase
  end

  // A ready on the limit cycle wins over the timeout
  assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = w_wait && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_class   <= C_NONE;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= r_bus_err | w_timeout;
      r_wait    <= (w_wait && !w_timeout) ? r_wait + WAIT_W'(1) : '0;
      if (r_state == S_DECODE) r_class <= w_class;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!r_bus_err) w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
                else if (w_timeout) w_next = S_IDLE;
      S_DECODE: w_next = (w_is_j || w_is_jal || (w_class == C_NONE)) ? S_FETCH : S_EXE;
      S_EXE:    if (r_class == C_BEQ) w_next = S_FETCH;
                else if ((r_class == C_LW) || (r_class == C_SW)) w_next = S_MEM;
                else w_next = S_WB;
      S_MEM:    if (mem_ready) w_next = (r_class == C_SW) ? S_FETCH : S_WB;
                else if (w_timeout) w_next = S_IDLE;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    EXTOp      = 1'b0;
    ALUOp      = 4'b0000;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 1'b0;
    NPCOp      = 2'b00;
    GPRSel     = 2'b00;
    WDSel      = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        if (w_is_j || w_is_jal) begin
          PCWrite    = 1'b1;
          NPCOp      = 2'b10;
          instr_done = 1'b1;
        end
        if (w_is_jal) begin
          RegWrite = 1'b1;
          GPRSel   = 2'b10;
          WDSel    = 2'b10;
        end
        illegal = (w_class == C_NONE) && !w_is_j && !w_is_jal;
      end
      S_EXE: begin
        case (r_class)
          C_ADD, C_ADDI, C_LW, C_SW: ALUOp = 4'b0001;
          C_SUB, C_BEQ:              ALUOp = 4'b0010;
          C_AND:                     ALUOp = 4'b0011;
          C_OR, C_ORI:               ALUOp = 4'b0100;
          C_SLT:                     ALUOp = 4'b0101;
          C_SLTU:                    ALUOp = 4'b0110;
          C_SLL, C_SLLV:             ALUOp = 4'b0111;
          C_SRL, C_SRLV:             ALUOp = 4'b1000;
          default:                   ALUOp = 4'b0000;
        endcase
        ALUSrcA = (r_class == C_SLL) || (r_class == C_SRL);
        ALUSrcB = (r_class == C_ADDI) || (r_class == C_ORI) ||
                  (r_class == C_LW) || (r_class == C_SW);
        EXTOp   = (r_class == C_ADDI) || (r_class == C_LW) || (r_class == C_SW);
        if (r_class == C_BEQ) begin
          PCWrite    = Zero;
          NPCOp      = 2'b01;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        mem_req    = 1'b1;
        IorD       = 1'b1;
        mem_we     = (r_class == C_SW);
        instr_done = mem_ready && (r_class == C_SW);
      end
      S_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        WDSel      = (r_class == C_LW) ? 2'b01 : 2'b00;
        GPRSel     = ((r_class == C_ADDI) || (r_class == C_ORI) || (r_class == C_LW)) ?
                     2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  assign bus_err = r_bus_err;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues per-cycle expected control
// vectors, a negedge monitor pops and compares against the DUT outputs.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, EXTOp;
  logic [3:0] ALUOp;
  logic       ALUSrcA, ALUSrcB;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic       instr_done, illegal, bus_err;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  string       qn[$];
  logic [24:0] qv[$];

  mc_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .instr_done(instr_done), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {state, mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, EXTOp,
                ALUOp, ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel, instr_done,
                illegal, bus_err};

  localparam logic [24:0] MREQ = 25'(1) << 21, MWE  = 25'(1) << 20,
                          IORD = 25'(1) << 19, IRW  = 25'(1) << 18,
                          PCW  = 25'(1) << 17, REGW = 25'(1) << 16,
                          EXT  = 25'(1) << 15, SRCA = 25'(1) << 10,
                          SRCB = 25'(1) << 9,  DONE = 25'(1) << 2,
                          ILL  = 25'(1) << 1,  BERR = 25'(1);

  function automatic logic [24:0] st(input int s);  return 25'(s) << 22; endfunction
  function automatic logic [24:0] alu(input int a); return 25'(a) << 11; endfunction
  function automatic logic [24:0] npc(input int a); return 25'(a) << 7;  endfunction
  function automatic logic [24:0] gpr(input int a); return 25'(a) << 5;  endfunction
  function automatic logic [24:0] wd(input int a);  return 25'(a) << 3;  endfunction

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;

  // Monitor: one comparison per queued expectation
  always @(negedge clk) begin
    if (qv.size() > 0) begin
      logic [24:0] e;
      string       n;
      e = qv.pop_front();
      n = qn.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s got=%b want=%b", n, obs, e);
      end
    end
  end

  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [24:0] e, input string nm);
    @(posedge clk);
    #1;
    Op = op; Funct = fn; Zero = z; mem_ready = rdy;
    qv.push_back(e);
    qn.push_back(nm);
  endtask

  task automatic rst_cyc(input logic r, input logic [24:0] e, input string nm);
    @(posedge clk);
    #1;
    rstn = r;
    qv.push_back(e);
    qn.push_back(nm);
  endtask

  logic [24:0] F;
  logic [24:0] FW;

  initial begin
    F  = st(1) | MREQ | IRW | PCW;
    FW = st(1) | MREQ;
    rstn = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b1;
    rst_cyc(1'b0, st(0), "reset");
    rst_cyc(1'b1, st(0), "idle");

    // addi: 0,1,2,3,5,1
    cyc(OP_ADDI, 6'd0, 0, 1, F, "addi_fetch");
    cyc(OP_ADDI, 6'd0, 0, 1, st(2), "addi_dec");
    cyc(OP_ADDI, 6'd0, 0, 1, st(3) | alu(1) | SRCB | EXT, "addi_exe");
    cyc(OP_ADDI, 6'd0, 0, 1, st(5) | REGW | gpr(1) | DONE, "addi_wb");

    // lw with 3 wait cycles in MEM; ready on the limit cycle must win
    cyc(OP_LW, 6'd0, 0, 1, F, "lw_fetch");
    cyc(OP_LW, 6'd0, 0, 1, st(2), "lw_dec");
    cyc(OP_LW, 6'd0, 0, 1, st(3) | alu(1) | SRCB | EXT, "lw_exe");
    for (int i = 0; i < 3; i++) cyc(OP_LW, 6'd0, 0, 0, st(4) | MREQ | IORD, "lw_mem_wait");
    cyc(OP_LW, 6'd0, 0, 1, st(4) | MREQ | IORD, "lw_mem_rdy");
    cyc(OP_LW, 6'd0, 0, 1, st(5) | REGW | gpr(1) | wd(1) | DONE, "lw_wb");

    cyc(OP_SW, 6'd0, 0, 1, F, "sw_fetch");
    cyc(OP_SW, 6'd0, 0, 1, st(2), "sw_dec");
    cyc(OP_SW, 6'd0, 0, 1, st(3) | alu(1) | SRCB | EXT, "sw_exe");
    cyc(OP_SW, 6'd0, 0, 1, st(4) | MREQ | MWE | IORD | DONE, "sw_mem");

    cyc(OP_BEQ, 6'd0, 1, 1, F, "beq1_fetch");
    cyc(OP_BEQ, 6'd0, 1, 1, st(2), "beq1_dec");
    cyc(OP_BEQ, 6'd0, 1, 1, st(3) | alu(2) | PCW | npc(1) | DONE, "beq_taken");
    cyc(OP_BEQ, 6'd0, 0, 1, F, "beq0_fetch");
    cyc(OP_BEQ, 6'd0, 0, 1, st(2), "beq0_dec");
    cyc(OP_BEQ, 6'd0, 0, 1, st(3) | alu(2) | npc(1) | DONE, "beq_not_taken");

    cyc(OP_JAL, 6'd0, 0, 1, F, "jal_fetch");
    cyc(OP_JAL, 6'd0, 0, 1, st(2) | PCW | npc(2) | REGW | gpr(2) | wd(2) | DONE, "jal_dec");
    cyc(OP_J, 6'd0, 0, 1, F, "j_fetch");
    cyc(OP_J, 6'd0, 0, 1, st(2) | PCW | npc(2) | DONE, "j_dec");

    cyc(OP_R, 6'b000000, 0, 1, F, "sll_fetch");
    cyc(OP_R, 6'b000000, 0, 1, st(2), "sll_dec");
    cyc(OP_R, 6'b000000, 0, 1, st(3) | alu(7) | SRCA, "sll_exe");
    cyc(OP_R, 6'b000000, 0, 1, st(5) | REGW | DONE, "sll_wb");

    cyc(OP_R, 6'b000110, 0, 1, F, "srlv_fetch");
    cyc(OP_R, 6'b000110, 0, 1, st(2), "srlv_dec");
    cyc(OP_R, 6'b000110, 0, 1, st(3) | alu(8), "srlv_exe");
    cyc(OP_R, 6'b000110, 0, 1, st(5) | REGW | DONE, "srlv_wb");

    cyc(OP_R, 6'b101011, 0, 1, F, "sltu_fetch");
    cyc(OP_R, 6'b101011, 0, 1, st(2), "sltu_dec");
    cyc(OP_R, 6'b101011, 0, 1, st(3) | alu(6), "sltu_exe");
    cyc(OP_R, 6'b101011, 0, 1, st(5) | REGW | DONE, "sltu_wb");

    cyc(OP_ORI, 6'd0, 0, 1, F, "ori_fetch");
    cyc(OP_ORI, 6'd0, 0, 1, st(2), "ori_dec");
    cyc(OP_ORI, 6'd0, 0, 1, st(3) | alu(4) | SRCB, "ori_exe");
    cyc(OP_ORI, 6'd0, 0, 1, st(5) | REGW | gpr(1) | DONE, "ori_wb");

    cyc(OP_R, 6'b100011, 0, 1, F, "subu_fetch");
    cyc(OP_R, 6'b100011, 0, 1, st(2), "subu_dec");
    cyc(OP_R, 6'b100011, 0, 1, st(3) | alu(2), "subu_exe");
    cyc(OP_R, 6'b100011, 0, 1, st(5) | REGW | DONE, "subu_wb");

    cyc(OP_BAD, 6'd0, 0, 1, F, "bad_fetch");
    cyc(OP_BAD, 6'd0, 0, 1, st(2) | ILL, "bad_dec");

    // Fetch never answered: 4 wait cycles then IDLE with sticky bus_err
    for (int i = 0; i < 4; i++) cyc(OP_ADDI, 6'd0, 0, 0, FW, "to_fetch_wait");
    cyc(OP_ADDI, 6'd0, 0, 0, st(0) | BERR, "to_idle");
    cyc(OP_ADDI, 6'd0, 0, 1, st(0) | BERR, "to_stuck");
    cyc(OP_ADDI, 6'd0, 0, 1, st(0) | BERR, "to_stuck2");

    rst_cyc(1'b0, st(0), "rst_clr_err");
    rst_cyc(1'b1, st(0), "idle2");
    cyc(OP_LW, 6'd0, 0, 1, F, "lw2_fetch");
    cyc(OP_LW, 6'd0, 0, 1, st(2), "lw2_dec");
    cyc(OP_LW, 6'd0, 0, 1, st(3) | alu(1) | SRCB | EXT, "lw2_exe");
    cyc(OP_LW, 6'd0, 0, 0, st(4) | MREQ | IORD, "lw2_mem");
    // Reset asserted mid-MEM with no clock edge before the sample
    rst_cyc(1'b0, st(0), "rst_mid_mem");
    rst_cyc(1'b1, st(0), "idle3");
    cyc(OP_ADDI, 6'd0, 0, 1, F, "post_rst_fetch");

    repeat (3) @(posedge clk);
    total++;
    if (qv.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", qv.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath: one shared instruction/data memory, one ALU, and an instruction register (IR).
- Sequences each instruction through IDLE/FETCH/DECODE/EXE/MEM/WB.
- Drives the datapath control signals with the existing encodings.
- Waits on a memory ready handshake, with a timeout watchdog.
- Supported ISA: add, sub, and, or, slt, sltu, addu, subu, sll, srl, sllv, srlv, addi, ori, lw, sw, beq, j, jal.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles mem_req may stay high without mem_ready before bus_err (range 1..255).

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
Op  in  6  IR[31:26]; valid from DECODE until the instruction ends
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write (meaningful only when mem_req=1)
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  out  1  load IR
PCWrite  out  1  load PC from the NPC output
RegWrite  out  1  register file write
EXTOp  out  1  1 = sign extend, 0 = zero extend
ALUOp  out  4  NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000
ALUSrcA  out  1  1 = shamt, 0 = rs
ALUSrcB  out  1  1 = extended immediate, 0 = rt
NPCOp  out  2  00 PC+4, 01 branch, 10 jump
GPRSel  out  2  00 rd, 01 rt, 10 $31
WDSel  out  2  00 ALU, 01 MEM, 10 PC
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse on an unsupported Op/Funct
bus_err  out  1  sticky memory-timeout flag
state  out  3  IDLE 0, FETCH 1, DECODE 2, EXE 3, MEM 4, WB 5

Behaviour:
- Reset: rstn low forces state=IDLE, clears the wait counter, the class register and bus_err.
- Outputs are combinational from the registered state and class register. In IDLE every output is 0.
- Any signal not listed for a state is 0 in that state.
- IDLE: if bus_err=0, go to FETCH next cycle; otherwise stay in IDLE until reset.
- FETCH: mem_req=1, IorD=0, mem_we=0.
  - If mem_ready: IRWrite=1, PCWrite=1, NPCOp=00, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: decode Op/Funct and latch the instruction class (Rtype/shift/addi/ori/lw/sw/beq/j/jal).
  - Unsupported code: illegal=1, go to FETCH with no state change to the datapath.
  - j: PCWrite=1, NPCOp=10, instr_done=1, go to FETCH.
  - jal: PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10 (writes PC+4, already incremented), instr_done=1, go to FETCH.
  - All others go to EXE.
- EXE: ALUOp as follows.
  - add/addu/addi/lw/sw: ADD.
  - sub/subu/beq: SUB.
  - and: AND.
  - or/ori: OR.
  - slt: SLT.
  - sltu: SLTU.
  - sll/sllv: SLL.
  - srl/srlv: SRL.
  - ALUSrcA=1 only for sll/srl.
  - ALUSrcB=1 for addi/ori/lw/sw.
  - EXTOp=1 for addi/lw/sw.
  - Next state: beq takes PCWrite=Zero, NPCOp=01, instr_done=1, go to FETCH. lw/sw go to MEM. Others go to WB.
- MEM: mem_req=1, IorD=1, mem_we=(sw).
  - On mem_ready, sw: instr_done=1, go to FETCH.
  - On mem_ready, lw: go to WB.
  - Otherwise hold.
- WB: RegWrite=1, instr_done=1, go to FETCH.
  - WDSel=01 for lw, else 00.
  - GPRSel=00 for R-type (including shifts), 01 for addi/ori/lw.
- Watchdog: an 8-bit counter increments each cycle with mem_req=1 and mem_ready=0, and clears when mem_ready=1 or on leaving the wait state.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0: set bus_err, go to IDLE, with no IRWrite/PCWrite.
  - mem_ready in the same cycle as the limit is reached wins: normal completion, no error.
- Latencies, assuming mem_ready is high immediately:
  - j/jal: 2 cycles.
  - beq: 3 cycles.
  - R-type/I-type ALU: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Reset mid-instruction returns asynchronously to IDLE. Any pending mem_req drops immediately; a partial access is not retried.

Test Plan:
- Reset, then mem_ready=1 always, addi (Op 001000) -> states 0,1,2,3,5,1. EXE: ALUOp=0001, ALUSrcB=1, EXTOp=1. WB: RegWrite=1, GPRSel=01, WDSel=00, instr_done=1.
- lw (Op 100011), mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with mem_req=1 and IorD=1; then WB with WDSel=01 and GPRSel=01.
- beq (Op 000100) with Zero=1 -> EXE: ALUOp=0010, PCWrite=1, NPCOp=01. Repeat with Zero=0 -> PCWrite=0; both return to FETCH.
- jal (Op 000011) -> DECODE: PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10; total 2 cycles. sll (Funct 000000) -> EXE: ALUSrcA=1, ALUOp=0111.
- Op 111111 -> illegal pulses exactly 1 cycle in DECODE, no RegWrite/PCWrite, next state FETCH.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> bus_err=1 after 4 wait cycles, state IDLE, stays in IDLE. Assert rstn low mid-MEM -> state=0, mem_req=0 immediately.
